// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and constants for the fetch controller.
//   fetch_state_t : controller FSM states
//   NOP_INSTR     : instruction word driven when no instruction is valid
//   wd_width()    : width of the watchdog counter for a given cycle limit
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    // Bits needed to count 0..limit; never narrower than one bit.
    function automatic int unsigned wd_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// fetch_controller_if: instruction-memory request/response bus.
//   imem_req_valid : request strobe (master -> slave)
//   imem_req_ready : request accept (slave -> master); handshake = valid & ready
//   imem_addr      : request address (master -> slave)
//   imem_rsp_valid : one response strobe per accepted request (slave -> master)
//   imem_rsp_data  : instruction word (slave -> master)
// Modports: master = fetch controller side, slave = instruction memory side.
interface fetch_controller_if #(
    parameter int unsigned N = 32
) ();

    logic         imem_req_valid;
    logic         imem_req_ready;
    logic [N-1:0] imem_addr;
    logic         imem_rsp_valid;
    logic [N-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: counts cycles spent waiting for an instruction-memory response.
//   clk, rst  : clock, asynchronous active-low reset
//   active    : controller is in WAIT or DRAIN
//   rsp       : response arrives this cycle (cancels the count)
//   restart   : controller changes state this cycle (clears the count)
//   expired   : the TIMEOUT_CYCLES-th consecutive waiting cycle without a response
// Used only when FETCH_TIMEOUT_EN is defined.
module fetch_watchdog
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic rsp,
    input  logic restart,
    output logic expired
);

    localparam int unsigned CntW = wd_width(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q;

    // cnt_q holds the number of completed waiting cycles, so the compare fires in
    // the TIMEOUT_CYCLES-th one. A response in that same cycle wins.
    assign expired = active & ~rsp & (cnt_q == LastCnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (!active || rsp || restart || expired) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: sequences the Fetch stage against an instruction memory with
// variable response latency and at most one request outstanding.
//   clk, rst      : clock, asynchronous active-low reset
//   PCF           : current PC (also the request address)
//   PCSrcW        : writeback redirect
//   BranchTakenE  : execute redirect
//   StallD        : Decode cannot accept an instruction this cycle
//   imem          : instruction-memory bus (master modport)
//   StallF        : 1 = hold the PC register
//   InstrF        : instruction to Decode (NOP unless valid, except while holding)
//   InstrValidF   : InstrF valid this cycle
//   fetch_err     : sticky watchdog error
// Optional build macro FETCH_TIMEOUT_EN adds a response watchdog that retries the
// current PC after TIMEOUT_CYCLES waiting cycles; without it fetch_err is 0.
module fetch_controller
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned N              = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        PCF,
    input  logic                PCSrcW,
    input  logic                BranchTakenE,
    input  logic                StallD,
    fetch_controller_if.master  imem,
    output logic                StallF,
    output logic [N-1:0]        InstrF,
    output logic                InstrValidF,
    output logic                fetch_err
);

    localparam logic [N-1:0] Nop = N'(NOP_INSTR);

    fetch_state_t state_q, state_d;
    logic [N-1:0] buf_q, buf_d;
    logic         redirect;
    logic         req_valid;
    logic         accept;
    logic         rsp_valid;
    logic         timeout;

    assign redirect  = PCSrcW | BranchTakenE;
    assign req_valid = (state_q == REQ);
    assign accept    = req_valid & imem.imem_req_ready;
    assign rsp_valid = imem.imem_rsp_valid;

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_addr      = PCF;

`ifdef FETCH_TIMEOUT_EN
    logic err_q;

    fetch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .active  ((state_q == WAIT) || (state_q == DRAIN)),
        .rsp     (rsp_valid),
        .restart (state_d != state_q),
        .expired (timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign fetch_err = err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
    assign fetch_err          = 1'b0;
`endif

    // Next state, hold buffer and the same-cycle Fetch outputs. StallF and
    // InstrValidF must react to the response/redirect in the cycle they occur.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        StallF      = 1'b1;
        InstrValidF = 1'b0;
        InstrF      = Nop;

        unique case (state_q)
            IDLE: begin
                // Redirects are ignored here: the PC is still at its reset value.
                state_d = REQ;
            end

            REQ: begin
                if (redirect) begin
                    StallF  = 1'b0;
                    state_d = accept ? DRAIN : REQ;
                end else if (accept) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (redirect) begin
                    StallF  = 1'b0;
                    state_d = (rsp_valid || timeout) ? REQ : DRAIN;
                end else if (rsp_valid && !StallD) begin
                    InstrF      = imem.imem_rsp_data;
                    InstrValidF = 1'b1;
                    StallF      = 1'b0;
                    state_d     = REQ;
                end else if (rsp_valid) begin
                    buf_d   = imem.imem_rsp_data;
                    state_d = HOLD;
                end else if (timeout) begin
                    // Abandon the response and retry the same PC.
                    state_d = REQ;
                end
            end

            HOLD: begin
                InstrF = buf_q;
                if (redirect) begin
                    InstrF  = Nop;
                    StallF  = 1'b0;
                    buf_d   = '0;
                    state_d = REQ;
                end else if (!StallD) begin
                    InstrValidF = 1'b1;
                    StallF      = 1'b0;
                    buf_d       = '0;
                    state_d     = REQ;
                end
            end

            DRAIN: begin
                // The stale response is swallowed; a new redirect only frees the PC.
                StallF = ~redirect;
                if (rsp_valid || timeout) begin
                    state_d = REQ;
                end
            end

            default: begin
                state_d = IDLE;
                buf_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
        end
    end

endmodule
